// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send/busy sequencer feeding uart_tx.
// Optional LF -> CR,LF expansion when UART_TX_FEEDER_CRLF_EN is defined.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              send,
  output logic [7:0]        data,
  input  logic              busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              send_q, send_d;
  logic [7:0]        data_q, data_d;
`ifdef UART_TX_FEEDER_CRLF_EN
  logic              cr_sent_q, cr_sent_d;
`endif

  logic       full_w, empty_w, do_wr, do_pop;
  logic [7:0] head;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign do_wr   = wr_en && !full_w;
  assign head    = mem[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    send_d     = send_q;
    data_d     = data_q;
    do_pop     = 1'b0;
`ifdef UART_TX_FEEDER_CRLF_EN
    cr_sent_d  = cr_sent_q;
`endif

    if (wr_en && full_w) overflow_d = 1'b1;
    if (do_wr)           wr_ptr_d   = wr_ptr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        send_d = 1'b0;
        if (!empty_w && !busy) begin
          send_d  = 1'b1;
          state_d = WAIT_ACK;
`ifdef UART_TX_FEEDER_CRLF_EN
          // A head LF is sent twice round the loop: first a CR that leaves it queued.
          if (head == 8'h0A && !cr_sent_q) begin
            data_d    = 8'h0D;
            cr_sent_d = 1'b1;
          end else begin
            data_d    = head;
            do_pop    = 1'b1;
            cr_sent_d = 1'b0;
          end
`else
          data_d = head;
          do_pop = 1'b1;
`endif
        end
      end
      WAIT_ACK: begin
        if (busy) begin
          send_d  = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_d = IDLE;
      end
      default: begin
        send_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (do_pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + {{ADDR_W{1'b0}}, do_wr} - {{ADDR_W{1'b0}}, do_pop};
  end

  // NOTE: storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      send_q     <= 1'b0;
      data_q     <= 8'h00;
`ifdef UART_TX_FEEDER_CRLF_EN
      cr_sent_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      send_q     <= send_d;
      data_q     <= data_d;
`ifdef UART_TX_FEEDER_CRLF_EN
      cr_sent_q  <= cr_sent_d;
`endif
    end
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign send     = send_q;
  assign data     = data_q;

endmodule
